// File: rtl/scan_index_gen_pkg.sv
// ---------------------------------------------------------------------------
// scan_pkg
// Shared encodings for the scan index generator.
//   mode_e    : stepping mode applied on each prescaler tick
//   dir_e     : bounce direction, also the bounce FSM state
//   INDEX_MAX : highest index value (the index is 3 bits wide)
// ---------------------------------------------------------------------------
package scan_pkg;

  typedef enum logic [1:0] {
    MODE_UP     = 2'b00,
    MODE_DOWN   = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam logic [2:0] INDEX_MAX = 3'd7;

endpackage

// File: rtl/scan_index_gen_if.sv
// ---------------------------------------------------------------------------
// scan_index_gen_if
// Control and status bundle of the scan index generator.
//   en, mode, load, load_val, div : control, driven by the master
//   index, step, wrap, dir        : status, driven by the slave (generator)
// ---------------------------------------------------------------------------
interface scan_index_gen_if #(
  parameter int DIV_WIDTH = 16
);

  logic                 en;
  logic [1:0]           mode;
  logic                 load;
  logic [2:0]           load_val;
  logic [DIV_WIDTH-1:0] div;
  logic [2:0]           index;
  logic                 step;
  logic                 wrap;
  logic                 dir;

  modport master (
    output en, mode, load, load_val, div,
    input  index, step, wrap, dir
  );

  modport slave (
    input  en, mode, load, load_val, div,
    output index, step, wrap, dir
  );

endinterface

// File: rtl/scan_index_gen_prescaler.sv
// ---------------------------------------------------------------------------
// scan_prescaler
// Rate divider for the scan index generator. Emits a tick once every div+1
// enabled cycles.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   en    : run enable; low clears the count and blocks ticks
//   clr   : synchronous count clear (used on index load)
//   div   : terminal count
//   tick  : combinational, high in the cycle the count has reached div
// ---------------------------------------------------------------------------
module scan_prescaler #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 clr,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] cnt;
  logic                 at_tc;

  // >= rather than == so that lowering div below the current count ticks on
  // the next cycle instead of running the counter all the way around.
  assign at_tc = (cnt >= div);
  assign tick  = en && at_tc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en || clr || at_tc) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/scan_index_gen.sv
// ---------------------------------------------------------------------------
// scan_index_gen
// Registered 3-bit scan index for the downstream 3-to-8 one-hot decoder.
// The index steps on each prescaler tick in up, down or bounce mode, or is
// held; a synchronous load overrides stepping and restarts the prescaler.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of scan_index_gen_if
//           en, mode, load, load_val, div in; index, step, wrap, dir out
//
// Bounce FSM (state held in dir):
//   state    | meaning
//   DIR_UP   | index counts up, at INDEX_MAX reverse to DIR_DOWN
//   DIR_DOWN | index counts down, at 0 reverse to DIR_UP
// ---------------------------------------------------------------------------
module scan_index_gen
  import scan_pkg::*;
#(
  parameter int DIV_WIDTH = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  scan_index_gen_if.slave bus
);

  logic       tick;
  logic [2:0] index_q;
  dir_e       dir_q;
  logic       step_q;
  logic       wrap_q;

  scan_prescaler #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (bus.en),
    .clr   (bus.load),
    .div   (bus.div),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      index_q <= '0;
      dir_q   <= DIR_UP;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      step_q <= 1'b0;
      wrap_q <= 1'b0;
      if (bus.load) begin
        // Load wins over a coincident tick; that tick is simply dropped.
        index_q <= bus.load_val;
        dir_q   <= DIR_UP;
      end else if (tick) begin
        case (mode_e'(bus.mode))
          MODE_UP: begin
            index_q <= index_q + 3'd1;
            step_q  <= 1'b1;
            wrap_q  <= (index_q == INDEX_MAX);
          end
          MODE_DOWN: begin
            index_q <= index_q - 3'd1;
            step_q  <= 1'b1;
            wrap_q  <= (index_q == 3'd0);
          end
          MODE_BOUNCE: begin
            step_q <= 1'b1;
            if (dir_q == DIR_UP) begin
              if (index_q == INDEX_MAX) begin
                index_q <= INDEX_MAX - 3'd1;
                dir_q   <= DIR_DOWN;
                wrap_q  <= 1'b1;
              end else begin
                index_q <= index_q + 3'd1;
              end
            end else begin
              if (index_q == 3'd0) begin
                index_q <= 3'd1;
                dir_q   <= DIR_UP;
                wrap_q  <= 1'b1;
              end else begin
                index_q <= index_q - 3'd1;
              end
            end
          end
          MODE_HOLD: begin
            // Prescaler keeps running; nothing observable changes.
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign bus.index = index_q;
  assign bus.dir   = dir_q;
  assign bus.step  = step_q;
  assign bus.wrap  = wrap_q;

endmodule

// File: tb/tb_scan_index_gen.sv
module tb_scan_index_gen;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  scan_index_gen_if #(.DIV_WIDTH(16)) bus ();

  scan_index_gen #(.DIV_WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [1:0]  mode;
    logic        load;
    logic [2:0]  load_val;
    logic [15:0] div;
    logic [2:0]  exp_index;
    logic        exp_step;
    logic        exp_wrap;
    logic        exp_dir;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic en, logic [1:0] mode, logic load, logic [2:0] lv,
                              logic [15:0] div, logic [2:0] ei, logic es, logic ew,
                              logic ed);
    vec_t v;
    v.en = en; v.mode = mode; v.load = load; v.load_val = lv; v.div = div;
    v.exp_index = ei; v.exp_step = es; v.exp_wrap = ew; v.exp_dir = ed;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [2:0] ei, input logic es,
                           input logic ew, input logic ed);
    check({tag, ".index"}, 32'(bus.index), 32'(ei));
    check({tag, ".step"},  32'(bus.step),  32'(es));
    check({tag, ".wrap"},  32'(bus.wrap),  32'(ew));
    check({tag, ".dir"},   32'(bus.dir),   32'(ed));
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic [1:0] mode, input logic load,
                       input logic [2:0] lv, input logic [15:0] div);
    bus.en = en; bus.mode = mode; bus.load = load; bus.load_val = lv; bus.div = div;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    drive(1'b0, 2'b00, 1'b0, 3'd0, 16'd0);

    // Table: up mode at div=0, then load 5 and bounce at div=0.
    vecs.push_back(mk(1, 2'b00, 0, 0, 0, 3'd1, 1, 0, 0));
    vecs.push_back(mk(1, 2'b00, 0, 0, 0, 3'd2, 1, 0, 0));
    vecs.push_back(mk(1, 2'b00, 0, 0, 0, 3'd3, 1, 0, 0));
    vecs.push_back(mk(1, 2'b00, 0, 0, 0, 3'd4, 1, 0, 0));
    vecs.push_back(mk(1, 2'b00, 0, 0, 0, 3'd5, 1, 0, 0));
    vecs.push_back(mk(1, 2'b00, 0, 0, 0, 3'd6, 1, 0, 0));
    vecs.push_back(mk(1, 2'b00, 0, 0, 0, 3'd7, 1, 0, 0));
    vecs.push_back(mk(1, 2'b00, 0, 0, 0, 3'd0, 1, 1, 0));
    vecs.push_back(mk(1, 2'b00, 0, 0, 0, 3'd1, 1, 0, 0));
    vecs.push_back(mk(1, 2'b00, 0, 0, 0, 3'd2, 1, 0, 0));
    vecs.push_back(mk(1, 2'b10, 1, 5, 0, 3'd5, 0, 0, 0));
    vecs.push_back(mk(1, 2'b10, 0, 0, 0, 3'd6, 1, 0, 0));
    vecs.push_back(mk(1, 2'b10, 0, 0, 0, 3'd7, 1, 0, 0));
    vecs.push_back(mk(1, 2'b10, 0, 0, 0, 3'd6, 1, 1, 1));
    vecs.push_back(mk(1, 2'b10, 0, 0, 0, 3'd5, 1, 0, 1));
    vecs.push_back(mk(1, 2'b10, 0, 0, 0, 3'd4, 1, 0, 1));
    vecs.push_back(mk(1, 2'b10, 0, 0, 0, 3'd3, 1, 0, 1));
    vecs.push_back(mk(1, 2'b10, 0, 0, 0, 3'd2, 1, 0, 1));
    vecs.push_back(mk(1, 2'b10, 0, 0, 0, 3'd1, 1, 0, 1));
    vecs.push_back(mk(1, 2'b10, 0, 0, 0, 3'd0, 1, 0, 1));
    vecs.push_back(mk(1, 2'b10, 0, 0, 0, 3'd1, 1, 1, 0));
    // Switching to up keeps dir; en low freezes everything.
    vecs.push_back(mk(1, 2'b00, 0, 0, 0, 3'd2, 1, 0, 0));
    vecs.push_back(mk(0, 2'b00, 0, 0, 0, 3'd2, 0, 0, 0));

    // Reset state
    #1;
    check_all("reset", 3'd0, 0, 0, 0);
    cyc();
    cyc();
    check_all("reset_hold", 3'd0, 0, 0, 0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].en, vecs[i].mode, vecs[i].load, vecs[i].load_val, vecs[i].div);
      cyc();
      check_all($sformatf("vec%0d", i), vecs[i].exp_index, vecs[i].exp_step,
                vecs[i].exp_wrap, vecs[i].exp_dir);
    end

    // Down mode, div=3: new index every 4 cycles, wrap on 0->7.
    drive(1, 2'b01, 1, 3'd0, 16'd3);
    cyc();
    check_all("down_load", 3'd0, 0, 0, 0);
    bus.load = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      logic [2:0] ei;
      cyc();
      ei = (i < 4) ? 3'd0 : (i < 8) ? 3'd7 : (i < 12) ? 3'd6 : 3'd5;
      check_all($sformatf("down%0d", i), ei, (i % 4) == 0, i == 4, 0);
    end

    // Load coincident with a tick in up mode, div=2.
    drive(1, 2'b00, 1, 3'd0, 16'd2);
    cyc();
    bus.load = 1'b0;
    cyc();
    cyc();
    check_all("ld_pre", 3'd0, 0, 0, 0);
    drive(1, 2'b00, 1, 3'd3, 16'd2);
    cyc();
    check_all("ld_tick", 3'd3, 0, 0, 0);
    bus.load = 1'b0;
    cyc();
    check_all("ld_p1", 3'd3, 0, 0, 0);
    cyc();
    check_all("ld_p2", 3'd3, 0, 0, 0);
    cyc();
    check_all("ld_p3", 3'd4, 1, 0, 0);

    // en dropped mid-count, div=5.
    drive(1, 2'b00, 1, 3'd0, 16'd5);
    cyc();
    bus.load = 1'b0;
    repeat (3) cyc();
    bus.en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check_all($sformatf("en_off%0d", i), 3'd0, 0, 0, 0);
    end
    bus.en = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      cyc();
      check_all($sformatf("en_on%0d", i), (i == 6) ? 3'd1 : 3'd0, i == 6, 0, 0);
    end

    // Hold mode with div=0: no step for 20 cycles.
    drive(1, 2'b11, 0, 3'd0, 16'd0);
    for (int i = 0; i < 20; i++) begin
      cyc();
      check_all($sformatf("hold%0d", i), 3'd1, 0, 0, 0);
    end

    // Lowering div below the running count ticks on the next cycle.
    drive(1, 2'b00, 1, 3'd0, 16'd5);
    cyc();
    bus.load = 1'b0;
    repeat (4) cyc();
    check_all("div_pre", 3'd0, 0, 0, 0);
    bus.div = 16'd2;
    cyc();
    check_all("div_drop", 3'd1, 1, 0, 0);

    // Asynchronous reset between edges during bounce at index 6, dir down.
    drive(1, 2'b10, 1, 3'd5, 16'd0);
    cyc();
    bus.load = 1'b0;
    cyc();
    cyc();
    cyc();
    check_all("bnc_pre", 3'd6, 1, 1, 1);
    #3;
    rst_n = 1'b0;
    #1;
    check_all("async_rst", 3'd0, 0, 0, 0);
    cyc();
    check_all("rst_held", 3'd0, 0, 0, 0);
    rst_n = 1'b1;
    cyc();
    check_all("post_rst", 3'd1, 1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/scan_index_gen.md
Name: scan_index_gen

Overview:
- Sequential index source that drives the 3-to-8 one-hot decoder stage directly downstream.
- Produces a registered 3-bit index that steps at a programmable rate, e.g. for LED chaser or digit-select scanning.
- Supports up, down, bounce and hold modes, synchronous load, and single-cycle step and wrap strobes for downstream logic.

Parameters:
- DIV_WIDTH, 16, width of the prescaler divide-value input and internal prescaler counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  run enable; low freezes index and clears prescaler.
- mode  input  2  00 up, 01 down, 10 bounce, 11 hold.
- load  input  1  synchronous load strobe.
- load_val  input  3  value written to index on load.
- div  input  DIV_WIDTH  prescaler terminal count; tick every div+1 enabled cycles.
- index  output  3  current index, registered, feeds decoder In.
- step  output  1  one-cycle pulse in the cycle index takes a new stepped value.
- wrap  output  1  one-cycle pulse on 7->0 (up), 0->7 (down), or a bounce reversal.
- dir  output  1  bounce direction: 0 up, 1 down.

Behaviour:
- Reset (rst_n low, asynchronous, effective immediately mid-operation):
  - index=0, step=0, wrap=0, dir=0, prescaler count=0.
  - First update after deassertion occurs on the next rising edge.
- Prescaler:
  - cnt increments each cycle while en=1.
  - tick asserts when cnt>=div; cnt then returns to 0. The >= compare makes a mid-count reduction of div tick on the next cycle.
  - div=0 gives a tick every enabled cycle.
  - en=0: cnt forced to 0, no tick, index/dir held, step=wrap=0.
- Latency: with en rising at edge k, the first tick and index update land at edge k+div+1. step and wrap are high in the same cycle the new index is visible.
- Priority per edge: rst_n > load > tick.
  - load=1: index<=load_val, cnt<=0, dir<=0, step=wrap=0. Applies regardless of en or mode; a coincident tick is discarded.
- On tick by mode:
  - 00 up: index<=index+1 mod 8; wrap=1 when old index=7.
  - 01 down: index<=index-1 mod 8; wrap=1 when old index=0.
  - 10 bounce, two-state FSM UP/DOWN held in dir:
    - UP: index<7 -> index+1. Index=7 -> index<=6, dir<=DOWN, wrap=1.
    - DOWN: index>0 -> index-1. Index=0 -> index<=1, dir<=UP, wrap=1.
  - 11 hold: prescaler keeps running; index, dir unchanged; step=wrap=0.
  - step=1 on every tick in modes 00/01/10.
- Mode changes are sampled each edge and take effect at the next tick.
  - dir is retained across mode changes and used unchanged on entering bounce.
  - dir is updated only in bounce mode, on load, and on reset.
- step and wrap are deasserted in every cycle without a qualifying tick. They never stay high for two consecutive cycles unless div=0.

Decomposition:
- Shared package scan_pkg holds:
  - mode encodings MODE_UP=2'b00, MODE_DOWN=2'b01, MODE_BOUNCE=2'b10, MODE_HOLD=2'b11.
  - dir encodings DIR_UP=1'b0, DIR_DOWN=1'b1.
  - INDEX_MAX=3'd7.
- One sub-module, scan_prescaler: inputs clk, rst_n, en, clr, div; output tick. The top block instantiates it and implements index/dir update logic.

Test Plan:
- Reset then en=1, mode=00, div=0 for 10 cycles -> index 1,2,...,7,0,1,2; step high every cycle; wrap high only when index becomes 0.
- mode=01, div=3, start index 0 -> index changes every 4 cycles: 7,6,5...; wrap with the 0->7 transition; step pulses exactly 1 cycle each.
- mode=10, div=0, load_val=5 loaded -> 6,7,6,5,4,3,2,1,0,1; dir 0 then 1 at 7->6, then 0 at 0->1; wrap at both reversals.
- load=1 with load_val=3 coincident with a tick in mode 00 -> index=3 next cycle, step=0; the next tick occurs div+1 cycles later.
- en dropped mid-count with div=5, cnt=3 -> index frozen; after en re-rises, the next step comes 6 cycles later. mode=11 with en=1 -> no step for 20 cycles.
- rst_n pulsed low between clock edges during bounce at index 6, dir=1 -> index=0, dir=0, step=wrap=0 immediately, without waiting for a clock edge.
